// File: rtl/rv32i_pkg.sv
// rv32i_pkg: load/store funct3 encodings and memory access FSM state type
package rv32i_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: lane shift, byte enables, two-word merge and load extension; MISALIGN_SPLIT_EN permits misaligned accesses
module mem_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  output logic        legal,
  output logic        split,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic [31:0] wd_lo,
  output logic [31:0] wd_hi,
  output logic [31:0] ldata
);
  logic [1:0] sz;
  logic [7:0] mask;
  logic [31:0] wsz, lsh;
  logic [63:0] wsh;
  logic f3_ok, sx;
  assign sz = funct3[1:0];
  assign sx = !funct3[2];
  assign f3_ok = is_store ? funct3 inside {F3_SB, F3_SH, F3_SW}
                          : funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  // lanes over two consecutive words: low nibble is the first word, high nibble the next
  assign mask = (sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : 8'h0f) << off;
  assign be_lo = mask[3:0];
  assign be_hi = mask[7:4];
  assign wsz = sz == 2'd0 ? {24'd0, wdata[7:0]} : sz == 2'd1 ? {16'd0, wdata[15:0]} : wdata;
  assign wsh = {32'd0, wsz} << {off, 3'b000};
  assign wd_lo = sz == 2'd0 ? {4{wdata[7:0]}} : wsh[31:0];
  assign wd_hi = wsh[63:32];
  assign lsh = 32'({hi, lo} >> {off, 3'b000});
  assign ldata = sz == 2'd0 ? {{24{sx & lsh[7]}}, lsh[7:0]}
               : sz == 2'd1 ? {{16{sx & lsh[15]}}, lsh[15:0]} : lsh;
`ifdef MISALIGN_SPLIT_EN
  assign legal = f3_ok;
  assign split = |mask[7:4];
`else
  assign legal = f3_ok && (sz == 2'd0 || (sz == 2'd1 ? !off[0] : off == 2'd0));
  assign split = 1'b0;
`endif
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store FSM driving a word-wide memory port with ack timeout; MISALIGN_SPLIT_EN enables split misaligned accesses
module mem_access_ctrl
  import rv32i_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic idle, acc, second, tmo, legal, split, st, flt;
  logic [2:0] f3;
  logic [31:0] a, wd, w1, base, wd_lo, wd_hi, ldata;
  logic [3:0] be_lo, be_hi;
  logic [CW-1:0] cnt;
  assign idle = state == IDLE;
  assign acc = state == ACC1 || state == ACC2;
  assign second = state == ACC2;
  assign tmo = cnt == CW'(ACK_TIMEOUT - 1);
  assign base = {a[31:2], 2'b00} + (second ? 32'd4 : 32'd0);
  // legality is judged on live inputs in IDLE, everything else on the latched request
  mem_align u_align (
    .funct3  (idle ? funct3 : f3),
    .is_store(idle ? is_store : st),
    .off     (idle ? addr[1:0] : a[1:0]),
    .wdata   (wd),
    .lo      (second ? w1 : mem_rdata),
    .hi      (mem_rdata),
    .legal   (legal),
    .split   (split),
    .be_lo   (be_lo),
    .be_hi   (be_hi),
    .wd_lo   (wd_lo),
    .wd_hi   (wd_hi),
    .ldata   (ldata)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = legal ? ACC1 : RESP;
      ACC1:    if (mem_ack) state_n = split ? ACC2 : RESP;
               else if (tmo) state_n = RESP;
      ACC2:    if (mem_ack || tmo) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= 1'b0;
      f3 <= '0;
      a <= '0;
      wd <= '0;
      w1 <= '0;
      flt <= 1'b0;
      cnt <= '0;
      rdata <= '0;
    end else begin
      if (idle && start) begin
        st <= is_store;
        f3 <= funct3;
        a <= addr;
        wd <= wdata;
        flt <= !legal;
      end else if (acc && !mem_ack && tmo) flt <= 1'b1;
      cnt <= acc && !mem_ack && !tmo ? cnt + CW'(1) : '0;
      if (state == ACC1 && mem_ack) w1 <= mem_rdata;
      if (acc && mem_ack && !st && state_n == RESP) rdata <= ldata;
    end
  end
  assign busy = !idle;
  assign done = state == RESP;
  assign fault = done && flt;
  assign mem_req = acc;
  assign mem_we = acc && st;
  assign mem_addr = acc ? base : '0;
  assign mem_be = acc ? (second ? be_hi : be_lo) : '0;
  assign mem_wdata = mem_we ? (second ? wd_hi : wd_lo) : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized accesses checked against a byte-level memory model
module tb_mem_access_ctrl;
  logic clk = 0, rst_n = 0, start = 0, is_store = 0, mem_ack = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, mem_rdata = 0;
  logic busy, done, fault, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] a; logic [3:0] be; logic we; logic [31:0] wd;} acc_t;
  acc_t seen[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_rdata, got_rd;
  int done_k, req_cycles;
  bit got_fault, stable_ok;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [31:0] w);
    return mem.exists(w) ? mem[w] : (w * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] x);
    logic [31:0] w;
    w = rd(x & ~32'd3);
    return w[8*x[1:0] +: 8];
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : f3[1:0] == 2'd2 ? 4 : 0;
  endfunction

  function automatic bit legal_op(input bit st, input logic [2:0] f3, input logic [31:0] x);
    int n;
    n = size_of(f3);
    if (n == 0 || (f3[2] && (st || n == 4))) return 0;
`ifdef MISALIGN_SPLIT_EN
    return 1;
`else
    return (x % n) == 0;
`endif
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic xact(input bit st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int w, input bit poke);
    int k, wc, n, nw, exp_k, exp_req;
    bit in_ph, exp_f, tout;
    logic [31:0] wa, d, ld;
    acc_t ph, cur;
    acc_t exp_q[$];
    seen.delete();
    stable_ok = 1; done_k = -1; got_fault = 0; req_cycles = 0; k = 0; wc = 0; in_ph = 0;
    @(negedge clk);
    start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_ack = 0;
    while (k < 80 && done_k < 0) begin
      @(negedge clk);
      k++;
      mem_ack = 0;
      if (done) begin
        done_k = k; got_fault = fault; got_rd = rdata;
      end else if (mem_req) begin
        req_cycles++;
        mem_rdata = rd(mem_addr);
        if (!in_ph) begin
          in_ph = 1; wc = w;
          ph.a = mem_addr; ph.be = mem_be; ph.we = mem_we; ph.wd = mem_wdata;
          seen.push_back(ph);
        end else if (mem_addr !== ph.a || mem_be !== ph.be || mem_we !== ph.we || mem_wdata !== ph.wd)
          stable_ok = 0;
        if (wc == 0) begin
          mem_ack = 1; in_ph = 0;
        end else wc--;
      end else mem_rdata = $urandom;
      start = poke && busy && !done;
    end
    start = 0; mem_ack = 0;
    if (done_k < 0) check("done_seen", done, 1);
    n = size_of(f3);
    nw = 0; tout = 0;
    if (legal_op(st, f3, a)) begin
      nw = ((a & 32'd3) + n > 4) ? 2 : 1;
      for (int i = 0; i < nw; i++) begin
        wa = (a & ~32'd3) + 32'(4 * i);
        cur.a = wa; cur.be = 0; cur.we = st; cur.wd = 0;
        for (int j = 0; j < 4; j++) begin
          d = wa + 32'(j) - a;
          if (d < 32'(n)) begin
            cur.be[j] = 1;
            cur.wd[8*j +: 8] = wd[8*int'(d) +: 8];
          end
        end
        exp_q.push_back(cur);
      end
      tout = w >= 16;
    end
    if (nw == 0) begin
      exp_k = 1; exp_f = 1; exp_req = 0;
    end else if (tout) begin
      exp_k = 17; exp_f = 1; exp_req = 16;
      while (exp_q.size() > 1) void'(exp_q.pop_back());
    end else begin
      exp_k = nw * (w + 1) + 1; exp_f = 0; exp_req = nw * (w + 1);
      if (!st) begin
        ld = 0;
        for (int i = 0; i < n; i++) ld[8*i +: 8] = byte_at(a + 32'(i));
        if (!f3[2] && n < 4 && ld[8*n-1]) ld = ld | ~((32'd1 << (8 * n)) - 1);
        exp_rdata = ld;
      end
    end
    check("done_cycle", done_k, exp_k);
    check("fault", got_fault, exp_f);
    check("req_cycles", req_cycles, exp_req);
    check("n_access", seen.size(), exp_q.size());
    for (int i = 0; i < seen.size() && i < exp_q.size(); i++) begin
      check("acc_addr", seen[i].a, exp_q[i].a);
      check("acc_be", seen[i].be, exp_q[i].be);
      check("acc_we", seen[i].we, exp_q[i].we);
      if (st) check("acc_wdata", seen[i].wd & lanes(exp_q[i].be), exp_q[i].wd);
    end
    if (exp_q.size() > 0) check("stable", stable_ok, 1);
    check("rdata", got_rd, exp_rdata);
    @(negedge clk);
    check("busy_after", busy, 0);
    check("done_pulse", done, 0);
    mem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    mem_ack = 0;
    check("idle_ack_ignored", {busy, mem_req}, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bit st;
    logic [2:0] f3;
    logic [31:0] a;
    int r, w;
    exp_rdata = 0; got_rd = 0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, fault, mem_req, mem_we, mem_be}, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1;
    mem[32'h100] = 32'h80FFFFFF;
    xact(0, 3'b000, 32'h103, 0, 2, 0);
    check("lb_dir_rdata", got_rd, 32'hFFFFFF80);
    check("lb_dir_latency", done_k, 4);
    xact(1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0);
    xact(0, 3'b010, 32'h0FFFFFFD, 0, 1, 0);
    xact(0, 3'b010, 32'hFFFFFFFE, 0, 0, 0);
    xact(0, 3'b010, 32'h40, 0, 20, 0);
    xact(0, 3'b010, 32'h44, 0, 15, 0);
    xact(1, 3'b010, 32'h80, $urandom, 1, 1);
    xact(0, 3'b011, 32'h80, 0, 0, 0);
    xact(1, 3'b100, 32'h80, 0, 0, 0);
    xact(0, 3'b001, 32'h121, 0, 0, 0);
    xact(1, 3'b001, 32'h123, 32'h00001234, 1, 0);
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    start = 0;
    check("rst_pre_req", mem_req, 1);
    rst_n = 0;
    @(negedge clk);
    check("rst_drop_req", mem_req, 0);
    check("rst_mid_ctrl", {busy, done, fault, mem_be}, 0);
    check("rst_mid_addr", mem_addr, 0);
    exp_rdata = 0;
    check("rst_mid_rdata", rdata, exp_rdata);
    rst_n = 1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_ack = 0;
    check("rst_ack_ignored", {busy, done, mem_req}, 0);
    @(negedge clk);
    check("rst_ack_rdata", rdata, exp_rdata);
    for (int t = 0; t < 40; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
      r = $urandom_range(0, 9);
      w = r == 0 ? 16 + $urandom_range(0, 3) : r == 1 ? 15 : $urandom_range(0, 3);
      xact(st, f3, a, $urandom, w, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
